// File: rtl/op_sequencer.sv
// Command sequencer: one command per valid/ready transfer, stepping through IDLE/EXEC/WB/RSP.
// Drives the external alu and accumulator register, then returns the new accumulator value.
module op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       alu_oc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNT_W-1:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, RSP} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] data;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_q <= '0;
      res   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) cmd_q <= '{op: cmd_op, data: cmd_data};
      if (state == EXEC && !cmd_q.op[3]) res <= alu_f;
      if (state == RSP && rsp_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Strobes decode only from registered state/op so they are glitch-free and one-hot-or-zero.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_oc    = '0;
    alu_b     = '0;
    reg_in    = '0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_ir    = 1'b0;
    reg_sl    = 1'b0;
    reg_il    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_oc    = cmd_q.op[2:0];
        alu_b     = cmd_q.data;
        state_nxt = WB;
      end
      WB: begin
        state_nxt = RSP;
        if (!cmd_q.op[3]) begin
          reg_ld = 1'b1;
          reg_in = res;
        end else begin
          case (cmd_q.op[2:0])
            3'b000: reg_cl  = 1'b1;
            3'b001: begin
              reg_ld = 1'b1;
              reg_in = cmd_q.data;
            end
            3'b010: reg_inc = 1'b1;
            3'b011: reg_dec = 1'b1;
            3'b100: begin
              reg_sr = 1'b1;
              reg_ir = cmd_q.data[0];
            end
            3'b101: begin
              reg_sl = 1'b1;
              reg_il = cmd_q.data[0];
            end
            default: ;
          endcase
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_a     = reg_out;
  assign rsp_data  = reg_out;
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer with behavioural alu and accumulator stubs.
module tb_op_sequencer;
  localparam int W  = 4;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data, alu_a, alu_b, alu_f, reg_in, reg_out, rsp_data;
  logic [2:0]   alu_oc;
  logic         reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [CW-1:0] cmd_count;
  logic [W-1:0] acc;
  logic [5:0]   strb;

  always #5 clk = ~clk;

  op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_oc(alu_oc), .alu_a(alu_a),
    .alu_b(alu_b), .alu_f(alu_f), .reg_cl(reg_cl), .reg_ld(reg_ld),
    .reg_inc(reg_inc), .reg_dec(reg_dec), .reg_sr(reg_sr), .reg_ir(reg_ir),
    .reg_sl(reg_sl), .reg_il(reg_il), .reg_in(reg_in), .reg_out(reg_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cmd_count(cmd_count)
  );

  function automatic logic [W-1:0] alu_fn(logic [2:0] oc, logic [W-1:0] a, logic [W-1:0] b);
    case (oc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return b;
      default: return a;
    endcase
  endfunction

  assign alu_f = alu_fn(alu_oc, alu_a, alu_b);

  // Accumulator register stub (the external register block)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc <= '0;
    else if (reg_cl)  acc <= '0;
    else if (reg_ld)  acc <= reg_in;
    else if (reg_inc) acc <= acc + 1'b1;
    else if (reg_dec) acc <= acc - 1'b1;
    else if (reg_sr)  acc <= {reg_ir, acc[W-1:1]};
    else if (reg_sl)  acc <= {acc[W-2:0], reg_il};
  end
  assign reg_out = acc;
  assign strb = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};

  // Reference model: accumulator value after a whole command
  function automatic logic [W-1:0] ref_next(logic [3:0] op, logic [W-1:0] d, logic [W-1:0] a);
    if (!op[3]) return alu_fn(op[2:0], a, d);
    case (op[2:0])
      3'd0: return '0;
      3'd1: return d;
      3'd2: return a + 1'b1;
      3'd3: return a - 1'b1;
      3'd4: return {d[0], a[W-1:1]};
      3'd5: return {a[W-2:0], d[0]};
      default: return a;
    endcase
  endfunction

  function automatic logic [5:0] ref_strb(logic [3:0] op);
    if (!op[3]) return 6'b010000;
    case (op[2:0])
      3'd0: return 6'b100000;
      3'd1: return 6'b010000;
      3'd2: return 6'b001000;
      3'd3: return 6'b000100;
      3'd4: return 6'b000010;
      3'd5: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  int           mon_cnt = 0;
  logic [W-1:0] model_acc = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected responses on each handshake, checks strobe exclusivity each cycle
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      mon_cnt = 0;
    end else begin
      chk("strobe_onehot", 32'($countones(strb) <= 1), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_data", rsp_data, exp_q.pop_front());
        chk("cmd_count", cmd_count, mon_cnt);
        mon_cnt = (mon_cnt + 1) % (1 << CW);
      end
    end
  end

  task automatic send(logic [3:0] op, logic [W-1:0] d, int hold, bit do_rst);
    logic [W-1:0] nacc, ein, held;
    logic [5:0]   es;
    int           waitc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = 1'($urandom_range(0, 1));
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    nacc = ref_next(op, d, model_acc);
    es   = ref_strb(op);
    ein  = !op[3] ? nacc : (op[2:0] == 3'd1 ? d : '0);
    model_acc = nacc;
    exp_q.push_back(nacc);
    // EXEC
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("exec_busy", {rsp_valid, cmd_ready}, 0);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_strobes", strb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      model_acc = '0;
      repeat (2) begin
        @(negedge clk); #1;
        chk("rst_no_strobe", strb, 0);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cmd_count", cmd_count, 0);
      return;
    end
    // WB
    @(negedge clk);
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("wb_strobe", strb, es);
    chk("wb_reg_in", reg_in, ein);
    chk("wb_ir", reg_ir, es[1] ? d[0] : 1'b0);
    chk("wb_il", reg_il, es[0] ? d[0] : 1'b0);
    chk("wb_rsp_valid", rsp_valid, 0);
    // RSP: must be present on the third cycle after accept
    @(negedge clk);
    rsp_ready = (hold == 0);
    #1;
    chk("rsp_latency", rsp_valid, 1);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_data = W'($urandom); rsp_ready = 1'b0;
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, held);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      cmd_valid = 1'b0; rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_done", rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    #12;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_strobes", {strb, reg_ir, reg_il}, 0);
    chk("reset_alu_oc", alu_oc, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_reg_in", reg_in, 0);
    chk("reset_cmd_count", cmd_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(4'b1001, 4'b0101, 0, 1'b1);   // reset mid-EXEC discards the load
    send(4'b1001, 4'b1010, 0, 1'b0);   // load
    send(4'b1110, 4'b0000, 0, 1'b0);   // read
    send(4'b1001, 4'b1111, 0, 1'b0);
    send(4'b0000, 4'b0010, 0, 1'b0);   // 1111 + 0010 truncates to 0001
    send(4'b1001, 4'b0110, 0, 1'b0);
    send(4'b1100, 4'b1011, 0, 1'b0);   // sr, ir=1 -> 1011
    send(4'b1101, 4'b0110, 0, 1'b0);   // sl, il=0 -> 0110
    send(4'b1111, 4'b0000, 5, 1'b0);   // backpressure
    repeat (5) send(4'b1111, W'($urandom), 0, 1'b0);
    send(4'b1001, 4'b1111, 0, 1'b0);
    send(4'b1010, 4'b0000, 0, 1'b0);   // inc wraps to 0
    send(4'b1011, 4'b0000, 0, 1'b0);   // dec wraps to 1111

    for (int k = 0; k < 1000; k++) begin
      send(4'($urandom_range(0, 15)), W'($urandom),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
           ($urandom_range(0, 99) == 0));
    end

    @(negedge clk); #3;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
